// File: rtl/blc_pkg.sv
// Shared constants and helpers for the binary-logarithm converter and its
// companion blocks.
package blc_pkg;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_NEAREST = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width of the packed {k, y} result.
    function automatic int tlog_width(input int w, input int f);
        return clog2(w) + f;
    endfunction

endpackage

// File: rtl/blc_lod.sv
// Combinational leading-one detector: one-hot leading-one position, its binary
// index and an all-zero flag.
module blc_lod
    import blc_pkg::*;
#(
    parameter  int W  = 16,
    localparam int KW = clog2(W)
) (
    input  logic [W-1:0]  x,
    output logic [W-1:0]  onehot,
    output logic [KW-1:0] k,
    output logic          zero
);

    // Scan upward so the highest set bit leaves the final index.
    always_comb begin
        k = '0;
        for (int i = 0; i < W; i++) begin
            k = x[i] ? KW'(i) : k;
        end
        zero   = (x == '0);
        onehot = zero ? '0 : ({{(W-1){1'b0}}, 1'b1} << k);
    end

endmodule

// File: rtl/blc_pipe.sv
// Two-stage Mitchell log2 converter: leading-one detect and mantissa align,
// then truncate or round into {k, y}, under a valid/ready handshake.
module blc_pipe
    import blc_pkg::*;
#(
    parameter  int W     = 16,
    parameter  int F     = 5,
    parameter  int ROUND = ROUND_TRUNC,
    localparam int KW    = clog2(W),
    localparam int TW    = tlog_width(W, F)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_x,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [TW-1:0] out_tlog,
    output logic          out_zero
);

    logic [W-1:0]  lod_onehot_s;
    logic [KW-1:0] lod_k_s;
    logic          lod_zero_s;
    logic [KW-1:0] shamt_s;
    logic [W-2:0]  m_s;

    logic          s1_valid_r;
    logic [KW-1:0] s1_k_r;
    logic [W-2:0]  s1_m_r;
    logic          s1_zero_r;

    logic          s1_advance_s;
    logic          in_ready_s;

    logic [W-1:0]  ext_s;
    logic [F-1:0]  y_raw_s;
    logic          round_bit_s;
    logic [F:0]    sum_s;
    logic [KW-1:0] k_n_s;
    logic [F-1:0]  y_n_s;

    logic          out_valid_r;
    logic [TW-1:0] out_tlog_r;
    logic          out_zero_r;

    blc_lod #(.W(W)) u_lod (
        .x      (in_x),
        .onehot (lod_onehot_s),
        .k      (lod_k_s),
        .zero   (lod_zero_s)
    );

    // Handshake: stage 1 drains whenever the output register is free or taken.
    always_comb begin
        s1_advance_s = !out_valid_r || out_ready;
        in_ready_s   = !s1_valid_r || s1_advance_s;
    end

    // Drop the leading one and MSB-align the remaining bits.
    always_comb begin
        shamt_s = KW'(W - 1) - lod_k_s;
        m_s     = (W-1)'((in_x & ~lod_onehot_s) << shamt_s);
    end

    // Stage-1 valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
        end else if (in_ready_s) begin
            s1_valid_r <= in_valid;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage-1 data, captured on each accepted operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_k_r    <= '0;
            s1_m_r    <= '0;
            s1_zero_r <= 1'b0;
        end else if (in_valid && in_ready_s) begin
            s1_k_r    <= lod_k_s;
            s1_m_r    <= m_s;
            s1_zero_r <= lod_zero_s;
        end else begin
            s1_k_r    <= s1_k_r;
            s1_m_r    <= s1_m_r;
            s1_zero_r <= s1_zero_r;
        end
    end

    // A zero appended below m makes the first dropped bit read as 0 when F = W-1.
    always_comb begin
        ext_s       = {s1_m_r, 1'b0};
        y_raw_s     = F'(ext_s >> (W - F));
        round_bit_s = (ROUND == ROUND_NEAREST) ? ext_s[W-1-F] : 1'b0;
        sum_s       = {1'b0, y_raw_s} + (F+1)'(round_bit_s);
        if (s1_zero_r) begin
            k_n_s = '0;
            y_n_s = '0;
        end else if (sum_s[F]) begin
            if (s1_k_r == KW'(W - 1)) begin
                k_n_s = KW'(W - 1);
                y_n_s = '1;
            end else begin
                k_n_s = s1_k_r + KW'(1);
                y_n_s = '0;
            end
        end else begin
            k_n_s = s1_k_r;
            y_n_s = sum_s[F-1:0];
        end
    end

    // Output register; holds steady while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_tlog_r  <= '0;
            out_zero_r  <= 1'b0;
        end else if (s1_advance_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_tlog_r <= {k_n_s, y_n_s};
                out_zero_r <= s1_zero_r;
            end else begin
                out_tlog_r <= out_tlog_r;
                out_zero_r <= out_zero_r;
            end
        end else begin
            out_valid_r <= out_valid_r;
            out_tlog_r  <= out_tlog_r;
            out_zero_r  <= out_zero_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_tlog  = out_tlog_r;
    assign out_zero  = out_zero_r;

endmodule

// File: tb/tb_blc_pipe.sv
// Scoreboard bench for blc_pipe: four configurations share one handshake and
// are checked against an arithmetic log2 model.
module tb_blc_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] x_r;

    logic        rdy_a [4];
    logic        ov_a  [4];
    logic        oz_a  [4];
    logic [15:0] tl_a  [4];
    logic [8:0]  tl0, tl1;
    logic [9:0]  tl2, tl3;

    int pw [4] = '{16, 16, 8, 32};
    int pf [4] = '{5, 5, 7, 5};
    int pr [4] = '{0, 1, 1, 0};

    typedef struct {
        logic [15:0] t;
        logic        z;
    } exp_s;
    exp_s q [4][$];

    int total = 0;
    int bad   = 0;
    int mode  = 0;
    int occ   [4];
    bit prev_stall [4];
    logic [15:0] prev_tl [4];
    logic        prev_z  [4];

    always #5 clk = ~clk;

    blc_pipe #(.W(16), .F(5), .ROUND(0)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(rdy_a[0]), .in_x(x_r[15:0]), .out_valid(ov_a[0]), .out_ready(out_ready),
        .out_tlog(tl0), .out_zero(oz_a[0]));
    blc_pipe #(.W(16), .F(5), .ROUND(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(rdy_a[1]), .in_x(x_r[15:0]), .out_valid(ov_a[1]), .out_ready(out_ready),
        .out_tlog(tl1), .out_zero(oz_a[1]));
    blc_pipe #(.W(8), .F(7), .ROUND(1)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(rdy_a[2]), .in_x(x_r[7:0]), .out_valid(ov_a[2]), .out_ready(out_ready),
        .out_tlog(tl2), .out_zero(oz_a[2]));
    blc_pipe #(.W(32), .F(5), .ROUND(0)) u3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(rdy_a[3]), .in_x(x_r), .out_valid(ov_a[3]), .out_ready(out_ready),
        .out_tlog(tl3), .out_zero(oz_a[3]));

    assign tl_a[0] = {7'd0, tl0};
    assign tl_a[1] = {7'd0, tl1};
    assign tl_a[2] = {6'd0, tl2};
    assign tl_a[3] = {6'd0, tl3};

    // log2(x) ~ k + frac/2^k, scaled by 2^F, floored or rounded half-up.
    function automatic logic [15:0] ref_log(input longint unsigned x, input int w,
                                            input int f, input int rnd);
        int k;
        longint unsigned frac, y;
        if (x == 64'd0) return 16'd0;
        k = 0;
        for (int i = 0; i < w; i++) if (x[i]) k = i;
        frac = x - (64'd1 << k);
        if (rnd == 0) y = (frac << f) >> k;
        else          y = (((frac << (f + 1)) >> k) + 64'd1) >> 1;
        if (y == (64'd1 << f)) begin
            if (k == w - 1) y = (64'd1 << f) - 64'd1;
            else begin k = k + 1; y = 64'd0; end
        end
        return 16'((longint'(k) << f) | y);
    endfunction

    function automatic longint unsigned xmask(input logic [31:0] x, input int w);
        if (w == 8)       return {56'd0, x[7:0]};
        else if (w == 16) return {48'd0, x[15:0]};
        else              return {32'd0, x};
    endfunction

    task automatic check(input string name, input int i, input longint act, input longint exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s inst=%0d got=%0h want=%0h", name, i, act, exp);
        end
    endtask

    // Push expectations; the two W=16 instances may take fixed constants.
    task automatic push_all(input logic [31:0] x, input bit uc, input logic [15:0] c0,
                            input logic [15:0] c1);
        exp_s e;
        longint unsigned xm;
        for (int i = 0; i < 4; i++) begin
            xm  = xmask(x, pw[i]);
            e.z = (xm == 64'd0);
            if (uc && i == 0)      e.t = c0;
            else if (uc && i == 1) e.t = c1;
            else                   e.t = ref_log(xm, pw[i], pf[i], pr[i]);
            q[i].push_back(e);
        end
    endtask

    task automatic send(input logic [31:0] x, input bit uc, input logic [15:0] c0,
                        input logic [15:0] c1);
        bit got;
        got = 1'b0;
        x_r = x;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (rdy_a[0]) begin
                push_all(x, uc, c0, c1);
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!got) check("accept_timeout", 0, 0, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_random(input int n, input int gap_max);
        logic [31:0] r;
        for (int j = 0; j < n; j++) begin
            r = $urandom >> $urandom_range(0, 31);
            if (j % 17 == 3) r = 32'hFFFF_FFFF;
            send(r, 1'b0, 16'd0, 16'd0);
            if (gap_max > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, gap_max));
        end
        in_valid = 1'b0;
    endtask

    task automatic drain;
        bit busy;
        mode = 0;
        busy = 1'b1;
        for (int n = 0; n < 100 && busy; n++) begin
            @(negedge clk);
            busy = 1'b0;
            for (int i = 0; i < 4; i++) if (q[i].size() != 0) busy = 1'b1;
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) check("drain_left", i, q[i].size(), 0);
    endtask

    // Consumer-side ready: always, random, or held low.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (mode == 0)      out_ready = 1'b1;
            else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
            else                out_ready = 1'b0;
        end
    end

    // Monitor: handshake rules, stall stability and in-order scoreboard.
    always @(negedge clk) begin
        exp_s e;
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                occ[i] = 0;
                prev_stall[i] = 1'b0;
            end else begin
                check("in_ready", i, rdy_a[i], !(occ[i] == 2 && !out_ready));
                if (occ[i] == 0) check("valid_empty", i, ov_a[i], 0);
                if (occ[i] == 2) check("valid_full", i, ov_a[i], 1);
                if (prev_stall[i]) begin
                    check("stall_valid", i, ov_a[i], 1);
                    check("stall_tlog", i, {tl_a[i], oz_a[i]}, {prev_tl[i], prev_z[i]});
                end
                if (ov_a[i] && out_ready) begin
                    if (q[i].size() == 0) begin
                        check("extra_output", i, 1, 0);
                    end else begin
                        e = q[i].pop_front();
                        check("tlog", i, tl_a[i], e.t);
                        check("zero", i, oz_a[i], e.z);
                    end
                    occ[i] = occ[i] - 1;
                end
                if (in_valid && rdy_a[i]) occ[i] = occ[i] + 1;
                prev_stall[i] = ov_a[i] && !out_ready;
                prev_tl[i] = tl_a[i];
                prev_z[i]  = oz_a[i];
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        x_r = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("rst_valid", i, ov_a[i], 0);
            check("rst_ready", i, rdy_a[i], 1);
            check("rst_tlog", i, tl_a[i], 0);
            check("rst_zero", i, oz_a[i], 0);
        end
        @(posedge clk); #1;

        send(32'h0000_8000, 1'b1, 16'h1E0, 16'h1E0);
        send(32'h0000_0001, 1'b1, 16'h000, 16'h000);
        send(32'h0000_0013, 1'b1, 16'h086, 16'h086);
        send(32'h0000_0000, 1'b1, 16'h000, 16'h000);
        send(32'h0000_00FF, 1'b1, 16'h0FF, 16'h100);
        send(32'h0000_FFFF, 1'b1, 16'h1FF, 16'h1FF);
        send(32'hFFFF_FFFF, 1'b1, 16'h1FF, 16'h1FF);
        send(32'h0000_0002, 1'b1, 16'h020, 16'h020);
        idle(1);
        drain();

        mode = 1;
        send_random(8, 0);
        send_random(300, 3);
        drain();

        mode = 2;
        send(32'h0000_1234, 1'b0, 16'd0, 16'd0);
        send(32'h0000_00F0, 1'b0, 16'd0, 16'd0);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) check("rst_mid_valid", i, ov_a[i], 0);
        for (int i = 0; i < 4; i++) q[i].delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        mode = 0;
        idle(6);

        mode = 1;
        send_random(60, 2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
